// File: rtl/alu_logop_dispatch.sv
// alu_logop_dispatch: issues RV32I AND/OR/XOR ops to the logic-op unit and returns its result
module alu_logop_dispatch #(
    parameter int LOGOP_LATENCY = 1
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_funct3,
    input  logic        instr_is_imm,
    input  logic [31:0] rs1_dat,
    input  logic [31:0] rs2_dat,
    input  logic [11:0] imm12,
    input  logic [4:0]  rd_addr,
    output logic        dat_ready,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [3:0]  decryptedOP,
    input  logic [31:0] LogOp_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_dat,
    output logic [4:0]  res_rd,
    output logic        illegal_op
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state;
    logic [2:0]  cnt;
    logic [3:0]  op;
    logic        legal;
    assign op = instr_funct3 == 3'b111 ? 4'd15 :
                instr_funct3 == 3'b110 ? 4'd14 :
                instr_funct3 == 3'b100 ? 4'd11 : 4'd0;
    assign legal = op != 4'd0;
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            instr_ready <= 1'b0;
            dat_ready   <= 1'b0;
            ALU_dat1    <= 32'd0;
            ALU_dat2    <= 32'd0;
            decryptedOP <= 4'd0;
            res_valid   <= 1'b0;
            res_dat     <= 32'd0;
            res_rd      <= 5'd0;
            illegal_op  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    instr_ready <= 1'b1;
                    // instr_ready gates acceptance so the first cycle after reset is never an accept
                    if (instr_valid && instr_ready) begin
                        instr_ready <= 1'b0;
                        ALU_dat1    <= legal ? rs1_dat : 32'd0;
                        ALU_dat2    <= !legal ? 32'd0 :
                                       instr_is_imm ? {{20{imm12[11]}}, imm12} : rs2_dat;
                        decryptedOP <= op;
                        dat_ready   <= legal;
                        res_rd      <= rd_addr;
                        res_dat     <= 32'd0;
                        illegal_op  <= !legal;
                        res_valid   <= !legal;
                        state       <= legal ? ISSUE : RESP;
                    end
                end
                ISSUE: begin
                    cnt   <= 3'(LOGOP_LATENCY);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        res_dat     <= LogOp_out;
                        illegal_op  <= 1'b0;
                        res_valid   <= 1'b1;
                        dat_ready   <= 1'b0;
                        ALU_dat1    <= 32'd0;
                        ALU_dat2    <= 32'd0;
                        decryptedOP <= 4'd0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_logop_dispatch.sv
// tb_alu_logop_dispatch: drives two dispatchers (latency 1 and 3) against a pipelined logic-op unit model
module tb_alu_logop_dispatch;
    logic        soc_clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid, instr_is_imm, res_ready;
    logic [2:0]  instr_funct3;
    logic [31:0] rs1_dat, rs2_dat;
    logic [11:0] imm12;
    logic [4:0]  rd_addr;
    logic        instr_ready [2];
    logic        dat_ready [2];
    logic [31:0] ALU_dat1 [2];
    logic [31:0] ALU_dat2 [2];
    logic [3:0]  decryptedOP [2];
    logic        res_valid [2];
    logic [31:0] res_dat [2];
    logic [4:0]  res_rd [2];
    logic        illegal_op [2];
    int checks = 0;
    int errors = 0;

    always #5 soc_clk = ~soc_clk;

    function automatic int lat(int i);
        return i == 0 ? 1 : 3;
    endfunction

    function automatic logic [31:0] unit_fn(logic [31:0] a, logic [31:0] b, logic [3:0] o);
        case (o)
            4'd15:   return a & b;
            4'd14:   return a | b;
            4'd11:   return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] p [4];
        logic [31:0] lo;
        assign lo = p[lat(g) - 1];
        always @(posedge soc_clk or negedge reset) begin
            if (!reset) p <= '{default: 32'h0};
            else begin
                p[0] <= dat_ready[g] ? unit_fn(ALU_dat1[g], ALU_dat2[g], decryptedOP[g]) : 32'h0;
                for (int k = 1; k < 4; k++) p[k] <= p[k-1];
            end
        end
        alu_logop_dispatch #(.LOGOP_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .soc_clk(soc_clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready[g]),
            .instr_funct3(instr_funct3), .instr_is_imm(instr_is_imm), .rs1_dat(rs1_dat),
            .rs2_dat(rs2_dat), .imm12(imm12), .rd_addr(rd_addr), .dat_ready(dat_ready[g]),
            .ALU_dat1(ALU_dat1[g]), .ALU_dat2(ALU_dat2[g]), .decryptedOP(decryptedOP[g]),
            .LogOp_out(lo), .res_valid(res_valid[g]), .res_ready(res_ready),
            .res_dat(res_dat[g]), .res_rd(res_rd[g]), .illegal_op(illegal_op[g])
        );
    end

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat %0d): got %h expected %h", nm, lat(i), act, exp);
        end
    endtask

    function automatic logic [31:0] sext(logic [11:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [3:0] op_of(logic [2:0] f3);
        case (f3)
            3'b111:  return 4'd15;
            3'b110:  return 4'd14;
            3'b100:  return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'b111:  return a & b;
            3'b110:  return a | b;
            3'b100:  return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_zero(string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, " instr_ready"}, i, instr_ready[i], 0);
            chk({nm, " dat_ready"}, i, dat_ready[i], 0);
            chk({nm, " ALU_dat1"}, i, ALU_dat1[i], 0);
            chk({nm, " ALU_dat2"}, i, ALU_dat2[i], 0);
            chk({nm, " decryptedOP"}, i, decryptedOP[i], 0);
            chk({nm, " res_valid"}, i, res_valid[i], 0);
            chk({nm, " res_dat"}, i, res_dat[i], 0);
            chk({nm, " res_rd"}, i, res_rd[i], 0);
            chk({nm, " illegal_op"}, i, illegal_op[i], 0);
        end
    endtask

    task automatic resp_chk(logic [31:0] ed, logic [4:0] rd, bit ill);
        for (int i = 0; i < 2; i++) begin
            chk("resp res_valid", i, res_valid[i], 1);
            chk("resp res_dat", i, res_dat[i], ed);
            chk("resp res_rd", i, res_rd[i], rd);
            chk("resp illegal_op", i, illegal_op[i], ill);
            chk("resp instr_ready", i, instr_ready[i], 0);
            chk("resp dat_ready", i, dat_ready[i], 0);
            chk("resp ALU_dat1", i, ALU_dat1[i], 0);
            chk("resp ALU_dat2", i, ALU_dat2[i], 0);
            chk("resp decryptedOP", i, decryptedOP[i], 0);
        end
    endtask

    task automatic txn(logic [2:0] f3, bit im, logic [31:0] a, logic [31:0] b, logic [11:0] iv,
                       logic [4:0] rd, int hold, logic [31:0] ed, bit ill);
        logic [31:0] op2;
        int seen [2];
        int drc [2];
        op2 = im ? sext(iv) : b;
        seen = '{0, 0};
        drc = '{0, 0};
        @(negedge soc_clk);
        for (int i = 0; i < 2; i++) chk("idle instr_ready", i, instr_ready[i], 1);
        instr_valid = 1'b1; instr_funct3 = f3; instr_is_imm = im;
        rs1_dat = a; rs2_dat = b; imm12 = iv; rd_addr = rd;
        @(posedge soc_clk);
        #1;
        instr_funct3 = 3'($urandom); instr_is_imm = 1'($urandom);
        rs1_dat = $urandom; rs2_dat = $urandom; imm12 = 12'($urandom); rd_addr = 5'($urandom);
        instr_valid = 1'($urandom);
        for (int c = 1; c <= 12 && (seen[0] == 0 || seen[1] == 0); c++) begin
            @(negedge soc_clk);
            for (int i = 0; i < 2; i++) if (seen[i] == 0) begin
                if (dat_ready[i]) begin
                    drc[i]++;
                    chk("issue ALU_dat1", i, ALU_dat1[i], a);
                    chk("issue ALU_dat2", i, ALU_dat2[i], op2);
                    chk("issue decryptedOP", i, decryptedOP[i], op_of(f3));
                end
                if (res_valid[i]) seen[i] = c;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("res_valid latency", i, seen[i], ill ? 1 : 2 + lat(i));
            chk("dat_ready cycles", i, drc[i], ill ? 0 : 1 + lat(i));
        end
        resp_chk(ed, rd, ill);
        for (int h = 0; h < hold; h++) begin
            @(negedge soc_clk);
            resp_chk(ed, rd, ill);
        end
        res_ready = 1'b1;
        @(posedge soc_clk);
        #1;
        res_ready = 1'b0;
        instr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("post res_valid", i, res_valid[i], 0);
            chk("post instr_ready", i, instr_ready[i], 1);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        bit          im;
        logic [31:0] a, b;
        logic [11:0] iv;
        logic [4:0]  rd;
        int          hold;
        logic [31:0] ed;
        bit          ill;
    } vec_t;
    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 12'h000, 5'd1, 0, 32'h00F0_1234, 1'b0};
        tbl[1] = '{3'b100, 1'b1, 32'h0000_00FF, 32'h1234_5678, 12'hF00, 5'd2, 0, 32'hFFFF_FFFF, 1'b0};
        tbl[2] = '{3'b000, 1'b0, 32'h1111_1111, 32'h2222_2222, 12'h000, 5'd5, 1, 32'h0000_0000, 1'b1};
        tbl[3] = '{3'b110, 1'b0, 32'hA000_0000, 32'h0000_000A, 12'h000, 5'd3, 5, 32'hA000_000A, 1'b0};
        tbl[4] = '{3'b111, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 12'h000, 5'd4, 0, 32'h1234_5678, 1'b0};
        tbl[5] = '{3'b110, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 12'h7FF, 5'd9, 2, 32'h0000_07FF, 1'b0};
        instr_valid = 0; instr_funct3 = 0; instr_is_imm = 0; res_ready = 0;
        rs1_dat = 0; rs2_dat = 0; imm12 = 0; rd_addr = 0;
        #12;
        chk_zero("in reset");
        @(negedge soc_clk);
        reset = 1'b1;
        foreach (tbl[n])
            txn(tbl[n].f3, tbl[n].im, tbl[n].a, tbl[n].b, tbl[n].iv, tbl[n].rd, tbl[n].hold,
                tbl[n].ed, tbl[n].ill);
        // abort while the latency-3 instance is still waiting on the unit
        @(negedge soc_clk);
        instr_valid = 1'b1; instr_funct3 = 3'b111; instr_is_imm = 1'b0;
        rs1_dat = 32'hFFFF_0000; rs2_dat = 32'h0F0F_0F0F; rd_addr = 5'd7;
        @(posedge soc_clk);
        #1 instr_valid = 1'b0;
        @(posedge soc_clk);
        @(posedge soc_clk);
        #2;
        chk("pre-abort dat_ready", 1, dat_ready[1], 1);
        reset = 1'b0;
        #1;
        chk_zero("async abort");
        @(negedge soc_clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge soc_clk);
            for (int i = 0; i < 2; i++) begin
                chk("post-abort res_valid", i, res_valid[i], 0);
                chk("post-abort dat_ready", i, dat_ready[i], 0);
            end
        end
        for (int i = 0; i < 2; i++) chk("post-abort instr_ready", i, instr_ready[i], 1);
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b, op2;
            logic [11:0] iv;
            bit          im;
            f3 = 3'($urandom);
            if ($urandom_range(3) != 0) f3 = ($urandom_range(2) == 0) ? 3'b100 : ($urandom_range(1) ? 3'b110 : 3'b111);
            a = $urandom; b = $urandom; iv = 12'($urandom); im = 1'($urandom);
            op2 = im ? sext(iv) : b;
            txn(f3, im, a, b, iv, 5'($urandom), $urandom_range(3), ref_res(f3, a, op2), op_of(f3) == 4'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
